seq_multiplier: RTL and testbench

//  Parametrised iterative shift-and-add multiplier: WIDTH x WIDTH -> 2*WIDTH product.

---
 rtl/mult_pkg.sv | 23 ++
 rtl/cla_nbit.sv | 52 +++++
 rtl/seq_multiplier.sv | 171 +++++++++++++++++
 tb/tb_seq_multiplier.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_pkg
//  Description : Shared types and constants for the iterative multiplier:
//                FSM state encoding and the iteration-counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

   // Multiplier sequencing states, explicit 2-bit encoding
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Counter must hold the value WIDTH itself (the terminal count)
   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/cla_nbit.sv
`default_nettype none
// ============================================================================
//  Module      : cla_nbit
//  Description : Parametrised carry-lookahead adder. Every carry is built
//                directly from the generate/propagate terms of the bits below
//                it, the N-bit generalisation of the 8-bit CLA.
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_nbit #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);

   logic [N-1:0] w_p;
   logic [N-1:0] w_g;
   logic [N:0]   w_c;

   assign w_p = a ^ b;
   assign w_g = a & b;
   assign w_c[0] = cin;

   // Each carry c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, flattened
   for (genvar i = 0; i < N; i++) begin : g_carry
      always_comb begin
         logic term;
         logic acc;
         acc  = 1'b0;
         for (int j = 0; j <= i; j++) begin
            term = w_g[j];
            for (int k = j + 1; k <= i; k++) begin
               term = term & w_p[k];
            end
            acc = acc | term;
         end
         term = cin;
         for (int k = 0; k <= i; k++) begin
            term = term & w_p[k];
         end
         w_c[i+1] = acc | term;
      end
   end

   assign sum  = w_p ^ w_c[N-1:0];
   assign cout = w_c[N];

endmodule
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : seq_multiplier
//  Description : Iterative shift-and-add WIDTH x WIDTH -> 2*WIDTH multiplier
//                with valid/ready handshakes on both sides. One partial
//                product is accumulated per CALC cycle through a CLA.
//                Optional feature macro: MULT_SIGNED_EN (adds in_signed port
//                for two's-complement operands via sign/magnitude).
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_multiplier
   import mult_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
`ifdef MULT_SIGNED_EN
   input  logic               in_signed,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] Y,
   output logic               busy
);

   localparam int CNT_W = cnt_w(WIDTH);
   localparam int PW    = 2 * WIDTH;

   state_t           state_q,     state_d;
   logic [PW-1:0]    mcand_q,     mcand_d;
   logic [WIDTH-1:0] mplier_q,    mplier_d;
   logic [PW-1:0]    acc_q,       acc_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic [PW-1:0]    y_q,         y_d;
   logic             in_ready_q,  in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q,      busy_d;
   logic             sign_q,      sign_d;

   logic [PW-1:0]    w_add_sum;
   logic             w_add_cout_unused;   // carry-out of the accumulate is dropped
   logic [WIDTH-1:0] w_a_op;
   logic [WIDTH-1:0] w_b_op;
   logic             w_sign_op;

   // Operand conditioning: magnitudes and result sign for signed mode
`ifdef MULT_SIGNED_EN
   always_comb begin
      w_a_op    = A;
      w_b_op    = B;
      w_sign_op = 1'b0;
      if (in_signed) begin
         // -2^(W-1) negates to itself, which reads correctly as unsigned 2^(W-1)
         if (A[WIDTH-1]) w_a_op = (~A) + {{(WIDTH-1){1'b0}}, 1'b1};
         if (B[WIDTH-1]) w_b_op = (~B) + {{(WIDTH-1){1'b0}}, 1'b1};
         w_sign_op = A[WIDTH-1] ^ B[WIDTH-1];
      end
   end
`else
   always_comb begin
      w_a_op    = A;
      w_b_op    = B;
      w_sign_op = 1'b0;
   end
`endif

   // Accumulate adder: acc + shifted multiplicand
   cla_nbit #(
      .N(PW)
   ) u_cla (
      .a   (acc_q),
      .b   (mcand_q),
      .cin (1'b0),
      .sum (w_add_sum),
      .cout(w_add_cout_unused)
   );

   // Next-state and datapath update for the IDLE/CALC/DONE sequence
   always_comb begin
      state_d     = state_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      y_d         = y_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      sign_d      = sign_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d    = ST_CALC;
               mcand_d    = {{WIDTH{1'b0}}, w_a_op};
               mplier_d   = w_b_op;
               acc_d      = '0;
               cnt_d      = '0;
               sign_d     = w_sign_op;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
            end
         end
         ST_CALC: begin
            if (cnt_q == CNT_W'(WIDTH)) begin
               // All partial products summed; apply sign on the way out
               state_d     = ST_DONE;
               busy_d      = 1'b0;
               out_valid_d = 1'b1;
               y_d         = sign_q ? ((~acc_q) + {{(PW-1){1'b0}}, 1'b1}) : acc_q;
            end else begin
               if (mplier_q[0]) acc_d = w_add_sum;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   // State and output registers; reset overrides any in-flight product
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         y_q         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         sign_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         y_q         <= y_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         sign_q      <= sign_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign Y         = y_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_multiplier
//  Description : Self-checking bench for seq_multiplier (WIDTH=4). Directed
//                scenarios plus a randomized regression against an
//                arithmetic reference product.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_multiplier;

   localparam int W   = 4;
   localparam int LAT = W + 1;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [W-1:0]   A = '0;
   logic [W-1:0]   B = '0;
`ifdef MULT_SIGNED_EN
   logic           in_signed = 1'b0;
`endif
   logic           out_valid;
   logic           out_ready = 1'b1;
   logic [2*W-1:0] Y;
   logic           busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   seq_multiplier #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .A        (A),
      .B        (B),
`ifdef MULT_SIGNED_EN
      .in_signed(in_signed),
`endif
      .out_valid(out_valid),
      .out_ready(out_ready),
      .Y        (Y),
      .busy     (busy)
   );

   // Reference product straight from integer arithmetic
   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic sgn);
      longint p;
      if (sgn) p = longint'($signed(a)) * longint'($signed(b));
      else     p = longint'(a) * longint'(b);
      return p[2*W-1:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer operands, wait for acceptance, then count edges until out_valid.
   // Inputs are scrambled after acceptance to show they are not re-sampled.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                        output int lat, output logic timeout);
      int n;
      A = a;
      B = b;
`ifdef MULT_SIGNED_EN
      in_signed = sgn;
`endif
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      tick();
      A = W'($urandom);
      B = W'($urandom);
`ifdef MULT_SIGNED_EN
      in_signed = ~sgn;
`endif
      lat = 0;
      timeout = 1'b1;
      for (int i = 1; i <= 4 * W; i++) begin
         in_valid = 1'($urandom);
         tick();
         if (out_valid) begin
            lat = i;
            timeout = 1'b0;
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      total++;
      if ({in_ready, out_valid, busy} !== 3'b100 || Y !== '0) begin
         bad++;
         $display("FAIL reset: rdy/vld/busy=%b Y=%0d, want 100 Y=0", {in_ready, out_valid, busy}, Y);
      end
   endtask

   task automatic test_directed();
      logic [W-1:0] av [3] = '{4'd15, 4'd0, 4'd9};
      logic [W-1:0] bv [3] = '{4'd15, 4'd9, 4'd0};
      logic [2*W-1:0] ev [3] = '{8'd225, 8'd0, 8'd0};
      int lat;
      logic to;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         issue(av[i], bv[i], 1'b0, lat, to);
         total++;
         if (to || lat != LAT) begin
            bad++;
            $display("FAIL latency %0d*%0d: got %0d (timeout=%b), want %0d", av[i], bv[i], lat, to, LAT);
         end
         total++;
         if (Y !== ev[i]) begin
            bad++;
            $display("FAIL product %0d*%0d: got %0d, want %0d", av[i], bv[i], Y, ev[i]);
         end
         tick();
         total++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL release %0d*%0d: in_ready=%b out_valid=%b, want 1/0", av[i], bv[i], in_ready, out_valid);
         end
      end
   endtask

   task automatic test_backpressure();
      int lat;
      logic to;
      int errs;
      out_ready = 1'b0;
      issue(4'd6, 4'd7, 1'b0, lat, to);
      total++;
      if (to || Y !== 8'd42) begin
         bad++;
         $display("FAIL bp_product: got %0d (timeout=%b), want 42", Y, to);
      end
      errs = 0;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         A = W'($urandom);
         B = W'($urandom);
         tick();
         if (out_valid !== 1'b1 || Y !== 8'd42 || in_ready !== 1'b0 || busy !== 1'b0) errs++;
      end
      total++;
      if (errs != 0) begin
         bad++;
         $display("FAIL bp_hold: %0d unstable cycles, want 0 (last Y=%0d vld=%b rdy=%b)", errs, Y, out_valid, in_ready);
      end
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL bp_release: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
      end
      tick();
      total++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL bp_no_accept: in_ready=%b busy=%b, want 1/0", in_ready, busy);
      end
   endtask

   task automatic test_reset_mid_calc();
      int lat;
      logic to;
      A = 4'd5;
      B = 4'd5;
      in_valid = 1'b1;
      tick();                 // handshake edge
      in_valid = 1'b0;
      tick();                 // now in second CALC cycle
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL midcalc_busy: got %b, want 1", busy);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if ({in_ready, out_valid, busy} !== 3'b100 || Y !== '0) begin
         bad++;
         $display("FAIL midcalc_reset: rdy/vld/busy=%b Y=%0d, want 100 Y=0", {in_ready, out_valid, busy}, Y);
      end
      out_ready = 1'b1;
      issue(4'd3, 4'd5, 1'b0, lat, to);
      total++;
      if (to || lat != LAT || Y !== 8'd15) begin
         bad++;
         $display("FAIL after_reset 3*5: Y=%0d lat=%0d, want 15 lat=%0d", Y, lat, LAT);
      end
      tick();
   endtask

`ifdef MULT_SIGNED_EN
   task automatic test_signed();
      logic [W-1:0] av [4] = '{4'h8, 4'h8, 4'hF, 4'hF};
      logic [W-1:0] bv [4] = '{4'h7, 4'h8, 4'h1, 4'hF};
      logic         sv [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic [2*W-1:0] ev [4] = '{8'hC8, 8'h40, 8'hFF, 8'd225};
      int lat;
      logic to;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         issue(av[i], bv[i], sv[i], lat, to);
         total++;
         if (to || lat != LAT || Y !== ev[i]) begin
            bad++;
            $display("FAIL signed %h*%h s=%b: Y=%h lat=%0d, want %h lat=%0d", av[i], bv[i], sv[i], Y, lat, ev[i], LAT);
         end
         tick();
      end
   endtask
`endif

   task automatic test_random();
      int lat;
      logic to;
      logic [W-1:0] a, b;
      logic sgn;
      logic [2*W-1:0] exp_y;
      int hold;
      for (int n = 0; n < 1500; n++) begin
         a = W'($urandom);
         b = W'($urandom);
`ifdef MULT_SIGNED_EN
         sgn = 1'($urandom);
`else
         sgn = 1'b0;
`endif
         exp_y = ref_mul(a, b, sgn);
         for (int d = $urandom_range(0, 2); d > 0; d--) tick();
         out_ready = 1'b0;
         issue(a, b, sgn, lat, to);
         total++;
         if (to || lat != LAT || Y !== exp_y) begin
            bad++;
            $display("FAIL random %0d: %h*%h s=%b Y=%h lat=%0d, want %h lat=%0d", n, a, b, sgn, Y, lat, exp_y, LAT);
         end
         hold = $urandom_range(0, 3);
         for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom);
            tick();
            total++;
            if (out_valid !== 1'b1 || Y !== exp_y || in_ready !== 1'b0) begin
               bad++;
               $display("FAIL random_hold %0d: Y=%h vld=%b rdy=%b, want %h 1 0", n, Y, out_valid, in_ready, exp_y);
            end
         end
         out_ready = 1'b1;
         tick();
         in_valid = 1'b0;
         total++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL random_release %0d: rdy=%b vld=%b, want 1 0", n, in_ready, out_valid);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid_calc();
`ifdef MULT_SIGNED_EN
      test_signed();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
